recfn_narrow_wb: RTL and testbench

RECFN_NARROW_WB -- requirements
Module: recfn_narrow_wb

---
 rtl/recfn_narrow_wb.sv | 118 +++++++++++
 tb/tb_recfn_narrow_wb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/recfn_narrow_wb.sv
// recfn_narrow_wb: 2-entry writeback buffer that converts recoded binary32 (33b) to IEEE binary32.
// Defining RECFN_WB_FFLAGS_ACCUM_EN adds io_fflags_clear / io_fflags, a sticky accumulator of dequeued flags.
module recfn_narrow_wb (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [32:0] io_in_out,
  input  logic [4:0]  io_in_exceptionFlags,
  input  logic [4:0]  io_in_tag,
`ifdef RECFN_WB_FFLAGS_ACCUM_EN
  input  logic        io_fflags_clear,
  output logic [4:0]  io_fflags,
`endif
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_bits_data,
  output logic [4:0]  io_out_bits_tag,
  output logic [4:0]  io_out_bits_flags
);

  // Entry layout: {recoded[42:10], flags[9:5], tag[4:0]}
  logic [42:0] mem_r [2];
  logic        wrPtr_r;
  logic        rdPtr_r;
  logic [1:0]  count_r;
  logic        enq_s;
  logic        deq_s;
  logic [42:0] head_s;

  function automatic logic [31:0] recToIeee(input logic [32:0] rec);
    logic        sign;
    logic [8:0]  e;
    logic [22:0] f;
    logic [23:0] sig;
    logic [8:0]  sh;
    logic [22:0] frac;
    logic [31:0] res;
    sign = rec[32];
    e    = rec[31:23];
    f    = rec[22:0];
    sig  = {1'b1, f};
    sh   = 9'd130 - e;
    frac = 23'(sig >> sh);
    if (e[8:6] == 3'b000) begin
      res = {sign, 31'h0000_0000};
    end else if (e[8:6] == 3'b111) begin
      res = {sign, 8'hFF, f};
    end else if (e[8:7] == 2'b11) begin
      res = {sign, 8'hFF, 23'h00_0000};
    end else if (e < 9'd130) begin
      res = {sign, 8'h00, frac};
    end else begin
      // Recoded bias is 129 above IEEE; only the low 8 bits matter for normals.
      res = {sign, e[7:0] - 8'd129, f};
    end
    return res;
  endfunction

  // Handshake decisions; reset suppresses both enqueue and dequeue.
  always_comb begin
    io_in_ready  = (count_r != 2'd2);
    io_out_valid = (count_r != 2'd0);
    enq_s        = io_in_valid & io_in_ready & ~reset;
    deq_s        = io_out_valid & io_out_ready & ~reset;
  end

  // Head decode, gated by valid so stale storage never reaches the outputs.
  always_comb begin
    head_s = mem_r[rdPtr_r];
    if (io_out_valid) begin
      io_out_bits_data  = recToIeee(head_s[42:10]);
      io_out_bits_flags = head_s[9:5];
      io_out_bits_tag   = head_s[4:0];
    end else begin
      io_out_bits_data  = 32'h0000_0000;
      io_out_bits_flags = 5'd0;
      io_out_bits_tag   = 5'd0;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_r <= 1'b0;
      rdPtr_r <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (enq_s) wrPtr_r <= ~wrPtr_r;
      if (deq_s) rdPtr_r <= ~rdPtr_r;
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, intentionally not reset.
  always_ff @(posedge clock) begin
    if (enq_s) mem_r[wrPtr_r] <= {io_in_out, io_in_exceptionFlags, io_in_tag};
  end

`ifdef RECFN_WB_FFLAGS_ACCUM_EN
  logic [4:0] fflags_r;
  assign io_fflags = fflags_r;

  // Sticky flags: clear applies before the OR so a same-cycle dequeue survives.
  always_ff @(posedge clock) begin
    if (reset) begin
      fflags_r <= 5'd0;
    end else begin
      fflags_r <= (io_fflags_clear ? 5'd0 : fflags_r) | (deq_s ? head_s[9:5] : 5'd0);
    end
  end
`endif

endmodule

// File: tb/tb_recfn_narrow_wb.sv
// Self-checking bench for recfn_narrow_wb: queue-based reference model plus directed literal checks.
module tb_recfn_narrow_wb;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [32:0] io_in_out;
  logic [4:0]  io_in_exceptionFlags;
  logic [4:0]  io_in_tag;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_bits_data;
  logic [4:0]  io_out_bits_tag;
  logic [4:0]  io_out_bits_flags;
`ifdef RECFN_WB_FFLAGS_ACCUM_EN
  logic        io_fflags_clear;
  logic [4:0]  io_fflags;
`endif

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [32:0] rec;
    logic [4:0]  fl;
    logic [4:0]  tg;
  } ent_t;
  ent_t q[$];
  logic [4:0] mFflags;

  recfn_narrow_wb dut (
    .clock(clock),
    .reset(reset),
    .io_in_valid(io_in_valid),
    .io_in_ready(io_in_ready),
    .io_in_out(io_in_out),
    .io_in_exceptionFlags(io_in_exceptionFlags),
    .io_in_tag(io_in_tag),
`ifdef RECFN_WB_FFLAGS_ACCUM_EN
    .io_fflags_clear(io_fflags_clear),
    .io_fflags(io_fflags),
`endif
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out_bits_data(io_out_bits_data),
    .io_out_bits_tag(io_out_bits_tag),
    .io_out_bits_flags(io_out_bits_flags)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value-range view of the recoded format, written from the encoding rules.
  function automatic logic [31:0] refDecode(input logic [32:0] rec);
    int      e;
    longint  sig;
    logic    s;
    logic [7:0] ex;
    e = int'(rec[31:23]);
    s = rec[32];
    if (e < 64) return {s, 31'h0};
    if (e >= 448) return {s, 8'hFF, rec[22:0]};
    if (e >= 384) return {s, 8'hFF, 23'h0};
    if (e < 130) begin
      sig = 64'd8388608 + longint'(rec[22:0]);
      sig = sig >> (130 - e);
      return {s, 8'h00, sig[22:0]};
    end
    ex = 8'(e - 129);
    return {s, ex, rec[22:0]};
  endfunction

  task automatic checkModel();
    chk("out_valid", 32'(io_out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(io_in_ready), 32'(q.size() != 2));
    if (q.size() > 0) begin
      chk("data", io_out_bits_data, refDecode(q[0].rec));
      chk("tag", 32'(io_out_bits_tag), 32'(q[0].tg));
      chk("flags", 32'(io_out_bits_flags), 32'(q[0].fl));
    end
`ifdef RECFN_WB_FFLAGS_ACCUM_EN
    chk("fflags", 32'(io_fflags), 32'(mFflags));
`endif
  endtask

  // One clock: compare at negedge, then advance the model with what the DUT sampled.
  task automatic step();
    bit         enq;
    bit         deq;
    ent_t       n;
    logic [4:0] hf;
    @(negedge clock);
    checkModel();
    enq = io_in_valid && (q.size() < 2) && !reset;
    deq = (q.size() > 0) && io_out_ready && !reset;
    n.rec = io_in_out;
    n.fl  = io_in_exceptionFlags;
    n.tg  = io_in_tag;
    hf = 5'd0;
    @(posedge clock);
    #1;
    if (reset) begin
      q.delete();
      mFflags = 5'd0;
    end else begin
      if (deq) begin
        hf = q[0].fl;
        void'(q.pop_front());
      end
      if (enq) q.push_back(n);
`ifdef RECFN_WB_FFLAGS_ACCUM_EN
      mFflags = (io_fflags_clear ? 5'd0 : mFflags) | hf;
`endif
    end
  endtask

  task automatic drive(input logic v, input logic [32:0] r, input logic [4:0] fl, input logic [4:0] tg);
    io_in_valid          = v;
    io_in_out            = r;
    io_in_exceptionFlags = fl;
    io_in_tag            = tg;
  endtask

  function automatic logic [32:0] randRec();
    logic [8:0] e;
    case ($urandom_range(0, 5))
      0:       e = 9'($urandom_range(0, 63));
      1:       e = 9'($urandom_range(64, 129));
      2:       e = 9'($urandom_range(384, 447));
      3:       e = 9'($urandom_range(448, 511));
      default: e = 9'($urandom_range(130, 383));
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  initial begin
    reset = 1'b1;
    io_out_ready = 1'b0;
    drive(1'b0, 33'd0, 5'd0, 5'd0);
`ifdef RECFN_WB_FFLAGS_ACCUM_EN
    io_fflags_clear = 1'b0;
`endif
    mFflags = 5'd0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_out_valid", 32'(io_out_valid), 32'd0);
    chk("reset_in_ready", 32'(io_in_ready), 32'd1);

    // 1.0 with tag 3
    io_out_ready = 1'b1;
    drive(1'b1, 33'h0_8000_0000, 5'd0, 5'd3);
    step();
    drive(1'b0, 33'd0, 5'd0, 5'd0);
    chk("one_valid", 32'(io_out_valid), 32'd1);
    chk("one_data", io_out_bits_data, 32'h3F80_0000);
    chk("one_tag", 32'(io_out_bits_tag), 32'd3);
    chk("one_flags", 32'(io_out_bits_flags), 32'd0);
    step();

    // -inf then NaN back to back
    drive(1'b1, {1'b1, 9'h180, 23'h0}, 5'd0, 5'd1);
    step();
    drive(1'b1, {1'b0, 9'h1C0, 23'h40_0000}, 5'b10000, 5'd2);
    chk("ninf_data", io_out_bits_data, 32'hFF80_0000);
    step();
    drive(1'b0, 33'd0, 5'd0, 5'd0);
    chk("nan_data", io_out_bits_data, 32'h7FC0_0000);
    chk("nan_tag", 32'(io_out_bits_tag), 32'd2);
    step();

    // Subnormal edge and zero
    drive(1'b1, {1'b0, 9'd129, 23'h0}, 5'b00011, 5'd4);
    step();
    drive(1'b1, {1'b0, 9'h000, 23'h12_3456}, 5'd0, 5'd5);
    chk("sub_data", io_out_bits_data, 32'h0040_0000);
    step();
    drive(1'b0, 33'd0, 5'd0, 5'd0);
    chk("zero_data", io_out_bits_data, 32'h0000_0000);
    step();

    // Backpressure: three attempts, two accepted
    io_out_ready = 1'b0;
    drive(1'b1, 33'h0_8000_0000, 5'd1, 5'd10);
    step();
    drive(1'b1, {1'b1, 9'h180, 23'h0}, 5'd2, 5'd11);
    step();
    chk("full_in_ready", 32'(io_in_ready), 32'd0);
    drive(1'b1, {1'b0, 9'h1C0, 23'h40_0000}, 5'd4, 5'd12);
    step();
    chk("full_still", 32'(io_in_ready), 32'd0);
    chk("stable_data", io_out_bits_data, 32'h3F80_0000);
    chk("stable_tag", 32'(io_out_bits_tag), 32'd10);
    drive(1'b0, 33'd0, 5'd0, 5'd0);
    io_out_ready = 1'b1;
    step();
    chk("drain_in_ready", 32'(io_in_ready), 32'd1);
    chk("drain_second", io_out_bits_data, 32'hFF80_0000);
    step();
    chk("drain_empty", 32'(io_out_valid), 32'd0);

    // Full with same-cycle dequeue: enqueue still refused
    io_out_ready = 1'b0;
    drive(1'b1, 33'h0_8000_0000, 5'd0, 5'd20);
    step();
    drive(1'b1, {1'b0, 9'd129, 23'h0}, 5'd0, 5'd21);
    step();
    io_out_ready = 1'b1;
    drive(1'b1, {1'b1, 9'h180, 23'h0}, 5'd0, 5'd22);
    step();
    drive(1'b0, 33'd0, 5'd0, 5'd0);
    chk("fullsim_tag", 32'(io_out_bits_tag), 32'd21);
    chk("fullsim_ready", 32'(io_in_ready), 32'd1);
    step();
    chk("fullsim_empty", 32'(io_out_valid), 32'd0);

    // Reset while full
    io_out_ready = 1'b0;
    drive(1'b1, 33'h0_8000_0000, 5'b11111, 5'd7);
    step();
    step();
    reset = 1'b1;
    io_out_ready = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 33'd0, 5'd0, 5'd0);
    chk("rst_full_valid", 32'(io_out_valid), 32'd0);
    chk("rst_full_ready", 32'(io_in_ready), 32'd1);
`ifdef RECFN_WB_FFLAGS_ACCUM_EN
    chk("rst_full_fflags", 32'(io_fflags), 32'd0);

    // Sticky flag accumulation and clear-with-dequeue
    drive(1'b1, 33'h0_8000_0000, 5'b00001, 5'd1);
    step();
    drive(1'b1, 33'h0_8000_0000, 5'b00100, 5'd2);
    step();
    drive(1'b0, 33'd0, 5'd0, 5'd0);
    step();
    chk("fflags_acc", 32'(io_fflags), 32'b00101);
    io_out_ready = 1'b0;
    drive(1'b1, 33'h0_8000_0000, 5'b10000, 5'd3);
    step();
    drive(1'b0, 33'd0, 5'd0, 5'd0);
    io_out_ready = 1'b1;
    io_fflags_clear = 1'b1;
    step();
    io_fflags_clear = 1'b0;
    chk("fflags_clr_deq", 32'(io_fflags), 32'b10000);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      io_out_ready = ($urandom_range(0, 9) < 7);
      drive(1'($urandom_range(0, 1)), randRec(), 5'($urandom), 5'($urandom));
`ifdef RECFN_WB_FFLAGS_ACCUM_EN
      io_fflags_clear = ($urandom_range(0, 7) == 0);
`endif
      step();
    end
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
